stroke_interp: RTL and testbench

- Sits between mouse/keyboard front end and pixel-render draw_control write port (WE, WriteX, WriteY, WritePixel).
- Converts sparse, jumpy mouse samples into continuous strokes: while the pen is held, it draws a 1-pixel Bresenham line from the last drawn point to each new mouse point, one pixel per clock.
- Output write stream is gated off during BFS Run.

---
 rtl/paint_pkg.sv | 19 +
 rtl/bresenham_step.sv | 43 ++++
 rtl/stroke_interp.sv | 166 ++++++++++++++++
 tb/tb_stroke_interp.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/paint_pkg.sv
// Shared types and canvas constants for the paint pipeline.
package paint_pkg;

  localparam int unsigned COORD_W  = 10;
  localparam int unsigned CANVAS_W = 512;
  localparam int unsigned CANVAS_H = 480;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [7:0]         pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    DOT,
    LINE
  } stroke_state_e;

  localparam pixel_t ERASE_PIXEL = 8'd0;

endpackage

// File: rtl/bresenham_step.sv
// One Bresenham step: advances (x,y) by one pixel toward the target and
// flags when the new point lands on the target.
module bresenham_step
  import paint_pkg::*;
#(
  parameter int unsigned CW = COORD_W
) (
  input  logic [CW-1:0]        x,
  input  logic [CW-1:0]        y,
  input  logic [CW-1:0]        tx,
  input  logic [CW-1:0]        ty,
  input  logic signed [CW+1:0] err,
  input  logic signed [CW+1:0] dx,
  input  logic signed [CW+1:0] dy,
  input  logic                 sx,   // 1: step x downwards
  input  logic                 sy,   // 1: step y downwards
  output logic [CW-1:0]        nx,
  output logic [CW-1:0]        ny,
  output logic signed [CW+1:0] nerr,
  output logic                 done
);

  logic signed [CW+1:0] e2;

  assign e2 = err <<< 1;

  // Both tests use the pre-step e2; a diagonal step applies both updates.
  always_comb begin
    nerr = err;
    nx   = x;
    ny   = y;
    if (e2 >= dy) begin
      nerr = nerr + dy;
      nx   = sx ? x - CW'(1) : x + CW'(1);
    end
    if (e2 <= dx) begin
      nerr = nerr + dx;
      ny   = sy ? y - CW'(1) : y + CW'(1);
    end
    done = (nx == tx) && (ny == ty);
  end

endmodule

// File: rtl/stroke_interp.sv
// Turns sparse mouse samples into continuous 1-pixel strokes, emitting one
// pixel write per clock toward the draw_control write port.
module stroke_interp #(
  parameter int unsigned CANVAS_W = paint_pkg::CANVAS_W,
  parameter int unsigned CANVAS_H = paint_pkg::CANVAS_H,
  parameter int unsigned CW       = paint_pkg::COORD_W
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Run,
  input  logic          PenDown,
  input  logic          Erase,
  input  logic [7:0]    ColorIn,
  input  logic [CW-1:0] MouseX,
  input  logic [CW-1:0] MouseY,
  output logic          WE,
  output logic [CW-1:0] WriteX,
  output logic [CW-1:0] WriteY,
  output logic [7:0]    WritePixel,
  output logic          Busy
);

  paint_pkg::stroke_state_e state, next_state;

  logic                 have_last;
  logic [CW-1:0]        last_x, last_y;
  logic [CW-1:0]        tgt_x, tgt_y;
  logic [CW-1:0]        cur_x, cur_y;
  logic [7:0]           colour;
  logic signed [CW+1:0] err, dx, dy;
  logic                 sx, sy;

  logic                 start_dot, start_line;
  logic signed [CW+1:0] mx_s, my_s, lx_s, ly_s, adx, ady;

  logic [CW-1:0]        step_x, step_y;
  logic signed [CW+1:0] step_err;
  logic                 step_done;

  assign mx_s = $signed({2'b00, MouseX});
  assign my_s = $signed({2'b00, MouseY});
  assign lx_s = $signed({2'b00, last_x});
  assign ly_s = $signed({2'b00, last_y});
  assign adx  = (MouseX >= last_x) ? mx_s - lx_s : lx_s - mx_s;
  assign ady  = (MouseY >= last_y) ? my_s - ly_s : ly_s - my_s;

  bresenham_step #(
    .CW(CW)
  ) u_step (
    .x   (cur_x),
    .y   (cur_y),
    .tx  (tgt_x),
    .ty  (tgt_y),
    .err (err),
    .dx  (dx),
    .dy  (dy),
    .sx  (sx),
    .sy  (sy),
    .nx  (step_x),
    .ny  (step_y),
    .nerr(step_err),
    .done(step_done)
  );

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= paint_pkg::IDLE;
    else          state <= next_state;
  end

  // Next-state decode; Run overrides everything and parks in IDLE.
  always_comb begin
    next_state = state;
    start_dot  = 1'b0;
    start_line = 1'b0;
    if (Run) begin
      next_state = paint_pkg::IDLE;
    end else begin
      case (state)
        paint_pkg::IDLE: begin
          start_dot  = PenDown && !have_last;
          start_line = PenDown && have_last &&
                       ((MouseX != last_x) || (MouseY != last_y));
          if (start_dot)       next_state = paint_pkg::DOT;
          else if (start_line) next_state = paint_pkg::LINE;
        end
        paint_pkg::DOT:  next_state = paint_pkg::IDLE;
        paint_pkg::LINE: if (step_done) next_state = paint_pkg::IDLE;
        default:         next_state = paint_pkg::IDLE;
      endcase
    end
  end

  // Stroke datapath and registered write port.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      WE         <= 1'b0;
      WriteX     <= '0;
      WriteY     <= '0;
      WritePixel <= '0;
      Busy       <= 1'b0;
      have_last  <= 1'b0;
      last_x     <= '0;
      last_y     <= '0;
      tgt_x      <= '0;
      tgt_y      <= '0;
      cur_x      <= '0;
      cur_y      <= '0;
      colour     <= '0;
      err        <= '0;
      dx         <= '0;
      dy         <= '0;
      sx         <= 1'b0;
      sy         <= 1'b0;
    end else begin
      WE   <= 1'b0;
      Busy <= (next_state != paint_pkg::IDLE);
      if (Run) begin
        have_last <= 1'b0;
      end else begin
        case (state)
          paint_pkg::IDLE: begin
            if (!PenDown) begin
              have_last <= 1'b0;
            end else if (start_dot || start_line) begin
              tgt_x  <= MouseX;
              tgt_y  <= MouseY;
              colour <= Erase ? paint_pkg::ERASE_PIXEL : ColorIn;
              cur_x  <= last_x;
              cur_y  <= last_y;
              dx     <= adx;
              dy     <= -ady;
              err    <= adx - ady;
              sx     <= (MouseX < last_x);
              sy     <= (MouseY < last_y);
            end
          end
          paint_pkg::DOT: begin
            WE         <= (32'(tgt_x) < CANVAS_W) && (32'(tgt_y) < CANVAS_H);
            WriteX     <= tgt_x;
            WriteY     <= tgt_y;
            WritePixel <= colour;
            last_x     <= tgt_x;
            last_y     <= tgt_y;
            have_last  <= 1'b1;
          end
          paint_pkg::LINE: begin
            cur_x      <= step_x;
            cur_y      <= step_y;
            err        <= step_err;
            WE         <= (32'(step_x) < CANVAS_W) && (32'(step_y) < CANVAS_H);
            WriteX     <= step_x;
            WriteY     <= step_y;
            WritePixel <= colour;
            if (step_done) begin
              last_x <= tgt_x;
              last_y <= tgt_y;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stroke_interp.sv
// Self-checking bench for stroke_interp: a pixel-queue reference model
// predicts the write stream from the mouse/pen inputs each cycle.
module tb_stroke_interp;

  localparam int CW       = 10;
  localparam int CANVAS_W = 512;
  localparam int CANVAS_H = 480;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          Run;
  logic          PenDown;
  logic          Erase;
  logic [7:0]    ColorIn;
  logic [CW-1:0] MouseX;
  logic [CW-1:0] MouseY;
  logic          WE;
  logic [CW-1:0] WriteX;
  logic [CW-1:0] WriteY;
  logic [7:0]    WritePixel;
  logic          Busy;

  stroke_interp #(
    .CANVAS_W(CANVAS_W),
    .CANVAS_H(CANVAS_H),
    .CW      (CW)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Run       (Run),
    .PenDown   (PenDown),
    .Erase     (Erase),
    .ColorIn   (ColorIn),
    .MouseX    (MouseX),
    .MouseY    (MouseY),
    .WE        (WE),
    .WriteX    (WriteX),
    .WriteY    (WriteY),
    .WritePixel(WritePixel),
    .Busy      (Busy)
  );

  always #10 Clk = ~Clk;

  typedef struct {
    int x;
    int y;
    int pix;
  } pt_t;

  // Reference model: pixels still to be emitted, one per clock.
  pt_t q[$];
  int  m_have, m_lx, m_ly;
  int  exp_we, exp_busy, exp_x, exp_y, exp_pix;

  int  total = 0;
  int  bad   = 0;
  int  we_cnt, we_lx, we_ly, we_pix, busy_cnt;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Queue every pixel of a line from (x0,y0) to (x1,y1), start excluded.
  task automatic push_line(input int x0, input int y0, input int x1, input int y1, input int pix);
    int  ddx, ddy, stx, sty, e, e2, x, y, n;
    pt_t p;
    ddx = (x1 > x0) ? x1 - x0 : x0 - x1;
    ddy = -((y1 > y0) ? y1 - y0 : y0 - y1);
    stx = (x0 < x1) ? 1 : -1;
    sty = (y0 < y1) ? 1 : -1;
    e   = ddx + ddy;
    x   = x0;
    y   = y0;
    n   = 0;
    while (((x != x1) || (y != y1)) && (n < 4096)) begin
      e2 = 2 * e;
      if (e2 >= ddy) begin e += ddy; x += stx; end
      if (e2 <= ddx) begin e += ddx; y += sty; end
      p.x = x; p.y = y; p.pix = pix;
      q.push_back(p);
      n++;
    end
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    pt_t p;
    int  mx, my, col;
    mx     = int'(MouseX);
    my     = int'(MouseY);
    col    = Erase ? 0 : int'(ColorIn);
    exp_we = 0;
    if (!Reset_n || Run) begin
      q.delete();
      m_have = 0;
    end else if (q.size() > 0) begin
      p       = q.pop_front();
      exp_we  = (p.x < CANVAS_W && p.y < CANVAS_H) ? 1 : 0;
      exp_x   = p.x;
      exp_y   = p.y;
      exp_pix = p.pix;
    end else if (!PenDown) begin
      m_have = 0;
    end else if (!m_have) begin
      p.x = mx; p.y = my; p.pix = col;
      q.push_back(p);
      m_have = 1; m_lx = mx; m_ly = my;
    end else if (mx != m_lx || my != m_ly) begin
      push_line(m_lx, m_ly, mx, my, col);
      m_lx = mx; m_ly = my;
    end
    exp_busy = (q.size() > 0) ? 1 : 0;
  endtask

  task automatic tick();
    @(posedge Clk);
    model_step();
    @(negedge Clk);
    check("we", int'(WE), exp_we);
    check("busy", int'(Busy), exp_busy);
    if (exp_we != 0) begin
      check("wx", int'(WriteX), exp_x);
      check("wy", int'(WriteY), exp_y);
      check("wpix", int'(WritePixel), exp_pix);
    end
    if (WE) begin
      we_cnt++;
      we_lx  = int'(WriteX);
      we_ly  = int'(WriteY);
      we_pix = int'(WritePixel);
    end
    if (Busy) busy_cnt++;
  endtask

  task automatic set_mouse(input int x, input int y);
    MouseX = CW'(x);
    MouseY = CW'(y);
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  initial begin
    int mx, my;
    Reset_n = 1'b0;
    Run     = 1'b0;
    PenDown = 1'b0;
    Erase   = 1'b0;
    ColorIn = 8'd0;
    set_mouse(0, 0);
    m_have = 0; m_lx = 0; m_ly = 0;
    we_cnt = 0; we_lx = 0; we_ly = 0; we_pix = 0; busy_cnt = 0;

    repeat (3) tick();
    check("rst_we", int'(WE), 0);
    check("rst_x", int'(WriteX), 0);
    check("rst_y", int'(WriteY), 0);
    check("rst_pix", int'(WritePixel), 0);
    check("rst_busy", int'(Busy), 0);
    Reset_n = 1'b1;
    tick();

    // Single dot on first pen-down.
    PenDown = 1'b1; ColorIn = 8'd5; set_mouse(100, 200);
    we_cnt = 0; busy_cnt = 0;
    repeat (4) tick();
    check("dot_cnt", we_cnt, 1);
    check("dot_x", we_lx, 100);
    check("dot_y", we_ly, 200);
    check("dot_pix", we_pix, 5);
    check("dot_busy", busy_cnt, 1);

    // Short diagonal-ish segment.
    we_cnt = 0;
    set_mouse(104, 202);
    repeat (7) tick();
    check("seg_cnt", we_cnt, 4);
    check("seg_end_x", we_lx, 104);
    check("seg_end_y", we_ly, 202);

    // Vertical erase stroke.
    PenDown = 1'b0; tick();
    PenDown = 1'b1; set_mouse(100, 200); repeat (3) tick();
    we_cnt = 0; Erase = 1'b1; set_mouse(100, 195);
    repeat (8) tick();
    check("erase_cnt", we_cnt, 5);
    check("erase_x", we_lx, 100);
    check("erase_y", we_ly, 195);
    check("erase_pix", we_pix, 0);
    Erase = 1'b0;

    // Line crossing the right canvas edge.
    PenDown = 1'b0; tick();
    PenDown = 1'b1; ColorIn = 8'd7; set_mouse(508, 10); repeat (3) tick();
    we_cnt = 0; busy_cnt = 0; set_mouse(515, 10);
    repeat (10) tick();
    check("clip_cnt", we_cnt, 3);
    check("clip_x", we_lx, 511);
    check("clip_busy", busy_cnt, 7);

    // Run aborts a line; the next stroke starts fresh with a dot.
    PenDown = 1'b0; tick();
    PenDown = 1'b1; set_mouse(10, 10); repeat (3) tick();
    we_cnt = 0; set_mouse(20, 10);
    for (int i = 0; i < 20 && we_cnt < 2; i++) tick();
    Run = 1'b1;
    repeat (4) tick();
    check("run_abort_cnt", we_cnt, 2);
    Run = 1'b0; set_mouse(30, 30); we_cnt = 0;
    repeat (5) tick();
    check("run_dot_cnt", we_cnt, 1);
    check("run_dot_x", we_lx, 30);
    check("run_dot_y", we_ly, 30);

    // Pen released mid-line: line completes, later press is a lone dot.
    we_cnt = 0; set_mouse(40, 35);
    repeat (2) tick();
    PenDown = 1'b0;
    repeat (15) tick();
    check("rel_cnt", we_cnt, 10);
    PenDown = 1'b1; set_mouse(200, 100); we_cnt = 0;
    repeat (5) tick();
    check("rel_dot_cnt", we_cnt, 1);
    check("rel_dot_x", we_lx, 200);

    // Asynchronous reset in the middle of a line.
    set_mouse(260, 100);
    repeat (5) tick();
    #3 Reset_n = 1'b0;
    #1;
    check("rst_mid_we", int'(WE), 0);
    check("rst_mid_busy", int'(Busy), 0);
    check("rst_mid_x", int'(WriteX), 0);
    tick();
    Reset_n = 1'b1;
    tick();

    // Randomized strokes.
    mx = 200; my = 200;
    for (int n = 0; n < 3000; n++) begin
      Run = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 5) PenDown = ~PenDown;
      if ($urandom_range(0, 99) < 5) Erase = ~Erase;
      ColorIn = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 99) < 2) begin
        mx = $urandom_range(0, 600);
        my = $urandom_range(0, 520);
      end else if ($urandom_range(0, 99) < 15) begin
        mx = clampi(mx + $urandom_range(0, 40) - 20, 0, 1023);
        my = clampi(my + $urandom_range(0, 40) - 20, 0, 1023);
      end
      set_mouse(mx, my);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
